// File: rtl/des_round_pipeline.sv
// NUM_ROUNDS-deep DES Feistel round pipeline with per-stage valid/ready, bubble collapsing,
// per-block encrypt/decrypt key order and sideband tag. Define DES_PIPE_OCCUPANCY_EN for o_occupancy.
module des_round_pipeline #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned TAG_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [31:0]             i_L,
    input  logic [31:0]             i_R,
    input  logic                    i_decrypt,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic [48*NUM_ROUNDS-1:0] i_keys,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [31:0]             o_L,
    output logic [31:0]             o_R,
    output logic                    o_decrypt,
    output logic [TAG_W-1:0]        o_tag
`ifdef DES_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(NUM_ROUNDS+1)-1:0] o_occupancy
`endif
);

    localparam int unsigned LAST = NUM_ROUNDS - 1;

    localparam int unsigned SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    // Row is the outer bit pair, column the inner four bits.
    function automatic logic [3:0] sbox_lut(input logic [2:0] n, input logic [5:0] b);
        return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
    endfunction

    // DES f: E expansion, key mix, S-boxes, P permutation (DES bit n sits at vector index 32-n).
    function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        x = {r[0], r[31:27], r[28:23], r[24:19], r[20:15], r[16:11],
             r[12:7], r[8:3], r[4:0], r[31]} ^ k;
        s = {sbox_lut(3'd0, x[47:42]), sbox_lut(3'd1, x[41:36]),
             sbox_lut(3'd2, x[35:30]), sbox_lut(3'd3, x[29:24]),
             sbox_lut(3'd4, x[23:18]), sbox_lut(3'd5, x[17:12]),
             sbox_lut(3'd6, x[11:6]),  sbox_lut(3'd7, x[5:0])};
        return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
                s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
                s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
                s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
    endfunction

    logic [NUM_ROUNDS-1:0] v_vec;
    logic [NUM_ROUNDS-1:0] rdy;

    for (genvar k = 0; k < NUM_ROUNDS; k++) begin : g_stage
        // Key n lives at bits [48(N-n) +: 48]; stage k+1 uses key k+1 (encrypt) or N-k (decrypt).
        localparam int unsigned ENC_LSB = 48 * (NUM_ROUNDS - 1 - k);
        localparam int unsigned DEC_LSB = 48 * k;

        logic             vin, d_in;
        logic [31:0]      l_in, r_in;
        logic [TAG_W-1:0] t_in;
        logic [47:0]      key;
        logic             v_q, v_d, d_q, d_d;
        logic [31:0]      l_q, l_d, r_q, r_d;
        logic [TAG_W-1:0] t_q, t_d;

        if (k == 0) begin : g_src
            assign vin  = i_valid;
            assign l_in = i_L;
            assign r_in = i_R;
            assign d_in = i_decrypt;
            assign t_in = i_tag;
        end else begin : g_src
            assign vin  = g_stage[k-1].v_q;
            assign l_in = g_stage[k-1].l_q;
            assign r_in = g_stage[k-1].r_q;
            assign d_in = g_stage[k-1].d_q;
            assign t_in = g_stage[k-1].t_q;
        end

        assign key = d_in ? i_keys[DEC_LSB +: 48] : i_keys[ENC_LSB +: 48];

        // A stage can move when it or any later stage is empty, or the sink accepts.
        assign rdy[k]   = i_ready | ~(&v_vec[NUM_ROUNDS-1:k]);
        assign v_vec[k] = v_q;

        always_comb begin
            v_d = v_q;
            l_d = l_q;
            r_d = r_q;
            d_d = d_q;
            t_d = t_q;
            if (rdy[k]) begin
                v_d = vin;
                if (vin) begin
                    l_d = r_in;
                    r_d = l_in ^ feistel_f(r_in, key);
                    d_d = d_in;
                    t_d = t_in;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                l_q <= '0;
                r_q <= '0;
                d_q <= 1'b0;
                t_q <= '0;
            end else begin
                v_q <= v_d;
                l_q <= l_d;
                r_q <= r_d;
                d_q <= d_d;
                t_q <= t_d;
            end
        end
    end

    assign o_ready   = rdy[0];
    assign o_valid   = g_stage[LAST].v_q;
    assign o_L       = g_stage[LAST].l_q;
    assign o_R       = g_stage[LAST].r_q;
    assign o_decrypt = g_stage[LAST].d_q;
    assign o_tag     = g_stage[LAST].t_q;

`ifdef DES_PIPE_OCCUPANCY_EN
    localparam int unsigned OCC_W = $clog2(NUM_ROUNDS + 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer, out_xfer;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;

    // Simultaneous in/out transfers cancel; a full pipe cannot accept without emitting.
    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign o_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_des_round_pipeline.sv
// Bench for des_round_pipeline: DES reference model + scoreboard queue, 16-round and 1-round instances.
module tb_des_round_pipeline;

    localparam int NR = 16;

    localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,
                                12,13,14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,
                                24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int P_T [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                                 2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                                  10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,
                                  26, 8,16, 7,27,20,13, 2,41,52,31,37,47,55,30,40,
                                  51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int S_T [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    logic clk = 1'b0;
    logic rst_n;
    logic i_valid, o_ready, i_decrypt, o_valid, i_ready, o_decrypt;
    logic [31:0] i_L, i_R, o_L, o_R;
    logic [7:0] i_tag, o_tag;
    logic [48*NR-1:0] i_keys;
    logic v1_valid, o1_ready, v1_decrypt, o1_valid, o1_decrypt;
    logic [31:0] v1_L, v1_R, o1_L, o1_R;
    logic [7:0] v1_tag, o1_tag;
    logic [47:0] keys1;
    logic one;
`ifdef DES_PIPE_OCCUPANCY_EN
    logic [4:0] occ;
    logic       occ1;
`endif

    always #5 clk = ~clk;

    des_round_pipeline #(.NUM_ROUNDS(NR), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_L(i_L), .i_R(i_R),
        .i_decrypt(i_decrypt), .i_tag(i_tag), .i_keys(i_keys), .o_valid(o_valid),
        .i_ready(i_ready), .o_L(o_L), .o_R(o_R), .o_decrypt(o_decrypt), .o_tag(o_tag)
`ifdef DES_PIPE_OCCUPANCY_EN
        , .o_occupancy(occ)
`endif
    );

    des_round_pipeline #(.NUM_ROUNDS(1), .TAG_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(v1_valid), .o_ready(o1_ready), .i_L(v1_L), .i_R(v1_R),
        .i_decrypt(v1_decrypt), .i_tag(v1_tag), .i_keys(keys1), .o_valid(o1_valid),
        .i_ready(one), .o_L(o1_L), .o_R(o1_R), .o_decrypt(o1_decrypt), .o_tag(o1_tag)
`ifdef DES_PIPE_OCCUPANCY_EN
        , .o_occupancy(occ1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int cyc   = 0;
    logic [47:0] kk [1:16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        int six, row, col;
        e = '0;
        for (int n = 0; n < 48; n++) e = {e[46:0], 1'(r >> (32 - E_T[n]))};
        e = e ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = int'((e >> (42 - 6 * b)) & 48'h3F);
            row = 2 * (six / 32) + (six % 2);
            col = (six / 2) % 16;
            s = {s[27:0], 4'(S_T[b][16 * row + col])};
        end
        p = '0;
        for (int n = 0; n < 32; n++) p = {p[30:0], 1'(s >> (32 - P_T[n]))};
        return p;
    endfunction

    // Returns {L, R} after n Feistel rounds; decrypt walks the keys backwards.
    function automatic logic [63:0] model_rounds(input logic [31:0] l, input logic [31:0] r,
                                                 input logic d, input int n);
        logic [31:0] tmp;
        for (int rnd = 1; rnd <= n; rnd++) begin
            tmp = l ^ model_f(r, kk[d ? n + 1 - rnd : rnd]);
            l = r;
            r = tmp;
        end
        return {l, r};
    endfunction

    task automatic key_schedule(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        cd = '0;
        for (int n = 0; n < 56; n++) cd = {cd[54:0], 1'(key >> (64 - PC1_T[n]))};
        c = cd[55:28];
        d = cd[27:0];
        for (int rnd = 1; rnd <= 16; rnd++) begin
            for (int s = 0; s < SH_T[rnd-1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            k = '0;
            for (int n = 0; n < 48; n++) k = {k[46:0], 1'(cd >> (56 - PC2_T[n]))};
            kk[rnd] = k;
        end
    endtask

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic        d;
        logic [7:0]  t;
        int          ent;
    } exp_t;
    exp_t q[$];

    // Scoreboard: everything sampled mid-cycle, ahead of the edge the transfers happen on.
    always @(negedge clk) begin
        logic [63:0] res;
        if (!rst_n) begin
            q.delete();
        end else begin
            cyc++;
            check("o_ready", 64'(o_ready), 64'((q.size() < NR) || i_ready));
            check("o_valid", 64'(o_valid), 64'((q.size() > 0) && (cyc - q[0].ent >= NR)));
`ifdef DES_PIPE_OCCUPANCY_EN
            check("occupancy", 64'(occ), 64'(q.size()));
`endif
            if (o_valid && q.size() > 0) begin
                check("o_L", 64'(o_L), 64'(q[0].l));
                check("o_R", 64'(o_R), 64'(q[0].r));
                check("o_decrypt", 64'(o_decrypt), 64'(q[0].d));
                check("o_tag", 64'(o_tag), 64'(q[0].t));
                if (i_ready) begin
                    void'(q.pop_front());
                    n_pop++;
                end
            end
            if (i_valid && o_ready) begin
                res = model_rounds(i_L, i_R, i_decrypt, NR);
                q.push_back('{res[63:32], res[31:0], i_decrypt, i_tag, cyc});
            end
        end
    end

    task automatic send_one(input logic [31:0] l, input logic [31:0] r, input logic d,
                            input logic [7:0] t, output int lat);
        @(posedge clk); #1;
        i_valid = 1'b1; i_L = l; i_R = r; i_decrypt = d; i_tag = t;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain(input string name);
        int guard = 0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        while (q.size() > 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check(name, 64'(q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, acc, pops0;
        rst_n = 1'b0; one = 1'b1;
        i_valid = 1'b0; i_L = '0; i_R = '0; i_decrypt = 1'b0; i_tag = '0; i_ready = 1'b1;
        v1_valid = 1'b0; v1_L = '0; v1_R = '0; v1_decrypt = 1'b0; v1_tag = '0;

        key_schedule(64'h133457799BBCDFF1);
        for (int n = 1; n <= 16; n++) i_keys[48 * (16 - n) +: 48] = kk[n];
        keys1 = kk[1];
        check("K1", 64'(kk[1]), 64'h1B02EFFC7072);
        check("K16", 64'(kk[16]), 64'hCB3D8B0E17F5);
        check("model 1 round", model_rounds(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 1), 64'hF0AAF0AA_EF4A6544);
        check("model 16 rounds", model_rounds(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 16), 64'h43423234_0A4CD995);

        repeat (3) @(posedge clk);
        #2;
        check("reset o_valid", 64'(o_valid), 64'(0));
        check("reset o_L/o_R", {o_L, o_R}, 64'(0));
        check("reset o_tag/o_decrypt", 64'({o_tag, o_decrypt}), 64'(0));
        check("reset o_ready", 64'(o_ready), 64'(1));
        check("reset dut1 o_valid", 64'(o1_valid), 64'(0));
        rst_n = 1'b1;

        // Reference encrypt vector and its decrypt round trip.
        send_one(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 8'h5A, lat);
        check("enc latency", 64'(lat), 64'(16));
        check("enc L/R", {o_L, o_R}, 64'h43423234_0A4CD995);
        check("enc tag/mode", 64'({o_tag, o_decrypt}), 64'({8'h5A, 1'b0}));
        @(posedge clk); #1;
        send_one(32'h0A4CD995, 32'h43423234, 1'b1, 8'hA5, lat);
        check("dec latency", 64'(lat), 64'(16));
        check("dec L/R", {o_L, o_R}, 64'hF0AAF0AA_CC00CCFF);
        check("dec tag/mode", 64'({o_tag, o_decrypt}), 64'({8'hA5, 1'b1}));
        @(posedge clk); #1;

        // Single-round instance.
        v1_valid = 1'b1; v1_L = 32'hCC00CCFF; v1_R = 32'hF0AAF0AA; v1_tag = 8'h33;
        @(posedge clk); #1;
        v1_valid = 1'b0;
        check("r1 o_valid", 64'(o1_valid), 64'(1));
        check("r1 L/R", {o1_L, o1_R}, 64'hF0AAF0AA_EF4A6544);
        check("r1 tag", 64'(o1_tag), 64'h33);
        @(posedge clk); #1;
        check("r1 empty", 64'(o1_valid), 64'(0));

        // Full stall: 20 offered, only NR absorbed.
        i_ready = 1'b0; acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_L = $urandom; i_R = $urandom; i_decrypt = 1'($urandom); i_tag = 8'(acc);
            @(negedge clk);
            if (o_ready) acc++;
        end
        check("accepted under stall", 64'(acc), 64'(NR));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("full o_ready", 64'(o_ready), 64'(0));
            check("full held tag", 64'({o_valid, o_tag}), 64'({1'b1, 8'h00}));
        end
        @(posedge clk); #1;
        pops0 = n_pop;
        drain("stall drain");
        check("stall drained count", 64'(n_pop - pops0), 64'(NR));

        // Back-to-back burst at full throughput.
        @(posedge clk); #1;
        pops0 = n_pop;
        for (int c = 0; c < 40; c++) begin
            i_valid = 1'b1; i_L = $urandom; i_R = $urandom; i_decrypt = 1'($urandom); i_tag = 8'($urandom);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (NR) @(posedge clk);
        #1;
        check("burst throughput", 64'(n_pop - pops0), 64'(40));

        // Alternating valid under random backpressure.
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            i_valid = (c % 2 == 0); i_L = $urandom; i_R = $urandom;
            i_decrypt = 1'($urandom); i_tag = 8'($urandom); i_ready = 1'($urandom);
        end
        @(posedge clk); #1;
        drain("bubble drain");

        // Reset with 7 blocks in flight.
        @(posedge clk); #1;
        i_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            i_valid = 1'b1; i_L = $urandom; i_R = $urandom; i_decrypt = 1'($urandom); i_tag = 8'(c + 100);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("pre-reset o_valid", 64'(o_valid), 64'(1));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async reset o_valid", 64'(o_valid), 64'(0));
        check("async reset L/R", {o_L, o_R}, 64'(0));
        check("async reset tag", 64'(o_tag), 64'(0));
`ifdef DES_PIPE_OCCUPANCY_EN
        check("async reset occupancy", 64'(occ), 64'(0));
`endif
        @(posedge clk); #2;
        rst_n = 1'b1;
        i_ready = 1'b1;
        send_one(32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 8'h77, lat);
        check("post-reset latency", 64'(lat), 64'(16));
        check("post-reset L/R", {o_L, o_R}, 64'h43423234_0A4CD995);
        check("post-reset tag", 64'(o_tag), 64'h77);
        @(posedge clk); #1;
        drain("final drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
